// File: rtl/p_unary_gen.sv
// p_unary_gen: streaming thermometer-code generator behind a two-entry skid buffer.
// Each accepted count n becomes a W-bit code with the n low bits set, or its
// complement on request. Out-of-range counts are delivered as an all-zero code
// with an error flag, and a saturating counter records them.
module p_unary_gen #(
  parameter int unsigned W               = 16,
  parameter bit          P_COMPLIMENT_EN = 1'b1,
  localparam int unsigned NW             = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_in_vld,
  input  logic [NW-1:0] i_in_n,
  input  logic          i_in_inv,
  output logic          o_in_rdy,
  output logic          o_out_vld,
  output logic [W-1:0]  o_out_x,
  output logic          o_out_err,
  input  logic          i_out_rdy,
  output logic [7:0]    o_err_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   out_x_q, out_x_d;
  logic           out_err_q, out_err_d;
  logic [W-1:0]   skid_x_q, skid_x_d;
  logic           skid_err_q, skid_err_d;
  logic           in_rdy_q, in_rdy_d;
  logic           out_vld_q, out_vld_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic           accept;
  logic           drain;
  logic           n_legal;
  logic           eff_inv;
  logic [W-1:0]   therm;
  logic [W-1:0]   enc_x;
  logic           enc_err;

  // Encode the incoming count; zero and counts >= W carry no legal unary form.
  always_comb begin
    n_legal = (i_in_n != '0) && (i_in_n <= NW'(W - 1));
    eff_inv = i_in_inv & P_COMPLIMENT_EN;
    // Valid only for n < W, which is all that reaches enc_x when legal.
    therm   = ~({W{1'b1}} << i_in_n);
    enc_err = ~n_legal;
    if (!n_legal) begin
      enc_x = '0;
    end else if (eff_inv) begin
      enc_x = ~therm;
    end else begin
      enc_x = therm;
    end
  end

  // Handshake qualifiers; ready and valid are both taken from flops.
  always_comb begin
    accept = i_in_vld & in_rdy_q;
    drain  = out_vld_q & i_out_rdy;
  end

  // Skid-buffer occupancy, data movement and error counting.
  always_comb begin
    state_d    = state_q;
    out_x_d    = out_x_q;
    out_err_d  = out_err_q;
    skid_x_d   = skid_x_q;
    skid_err_d = skid_err_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d   = StOne;
          out_x_d   = enc_x;
          out_err_d = enc_err;
        end
      end
      StOne: begin
        if (accept && !drain) begin
          state_d    = StFull;
          skid_x_d   = enc_x;
          skid_err_d = enc_err;
        end else if (accept && drain) begin
          out_x_d   = enc_x;
          out_err_d = enc_err;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // Input ready is low here, so only a drain can occur.
        if (drain) begin
          state_d   = StOne;
          out_x_d   = skid_x_q;
          out_err_d = skid_err_q;
        end
      end
      default: state_d = StEmpty;
    endcase

    if (accept && enc_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    in_rdy_d  = (state_d != StFull);
    out_vld_d = (state_d != StEmpty);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      out_x_q    <= '0;
      out_err_q  <= 1'b0;
      skid_x_q   <= '0;
      skid_err_q <= 1'b0;
      in_rdy_q   <= 1'b1;
      out_vld_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      out_x_q    <= out_x_d;
      out_err_q  <= out_err_d;
      skid_x_q   <= skid_x_d;
      skid_err_q <= skid_err_d;
      in_rdy_q   <= in_rdy_d;
      out_vld_q  <= out_vld_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_in_rdy  = in_rdy_q;
  assign o_out_vld = out_vld_q;
  assign o_out_x   = out_x_q;
  assign o_out_err = out_err_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_p_unary_gen.sv
// Directed bench for p_unary_gen (W=16) plus a short randomized scoreboard soak.
module tb_p_unary_gen;

  localparam int W  = 16;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_in_vld;
  logic [NW-1:0] i_in_n;
  logic          i_in_inv;
  logic          i_out_rdy;

  logic          in_rdy, out_vld, out_err;
  logic [W-1:0]  out_x;
  logic [7:0]    err_cnt;

  logic          nc_in_rdy, nc_out_vld, nc_out_err;
  logic [W-1:0]  nc_out_x;
  logic [7:0]    nc_err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  p_unary_gen #(.W(W), .P_COMPLIMENT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .i_in_vld(i_in_vld), .i_in_n(i_in_n), .i_in_inv(i_in_inv),
    .o_in_rdy(in_rdy), .o_out_vld(out_vld), .o_out_x(out_x), .o_out_err(out_err),
    .i_out_rdy(i_out_rdy), .o_err_cnt(err_cnt)
  );

  p_unary_gen #(.W(W), .P_COMPLIMENT_EN(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .i_in_vld(i_in_vld), .i_in_n(i_in_n), .i_in_inv(i_in_inv),
    .o_in_rdy(nc_in_rdy), .o_out_vld(nc_out_vld), .o_out_x(nc_out_x), .o_out_err(nc_out_err),
    .i_out_rdy(i_out_rdy), .o_err_cnt(nc_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Step one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: set bits one by one, then complement if enabled.
  function automatic logic [W:0] model(input int n, input logic inv, input logic en);
    logic [W-1:0] t;
    t = '0;
    if (n == 0 || n >= W) return {1'b1, {W{1'b0}}};
    for (int i = 0; i < n; i++) t[i] = 1'b1;
    if (inv && en) t = ~t;
    return {1'b0, t};
  endfunction

  // Admission rule of the downstream unary checker.
  function automatic logic admits(input logic [W-1:0] x, input logic en);
    logic [W-1:0] t;
    for (int k = 1; k < W; k++) begin
      t = '0;
      for (int i = 0; i < k; i++) t[i] = 1'b1;
      if (x == t) return 1'b1;
      if (en && x == ~t) return 1'b1;
    end
    return 1'b0;
  endfunction

  logic [W:0] exp_q[$];
  logic [W:0] e;

  initial begin
    rst = 1'b1; i_in_vld = 1'b0; i_in_n = '0; i_in_inv = 1'b0; i_out_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_vld", 32'(out_vld), 32'd0);
    chk("reset_rdy", 32'(in_rdy), 32'd1);
    chk("reset_x", 32'(out_x), 32'd0);
    chk("reset_err", 32'(out_err), 32'd0);
    chk("reset_cnt", 32'(err_cnt), 32'd0);

    // Legal encode n=3.
    i_in_vld = 1'b1; i_in_n = 5'd3; i_in_inv = 1'b0;
    tick();
    i_in_vld = 1'b0;
    chk("legal_vld", 32'(out_vld), 32'd1);
    chk("legal_x", 32'(out_x), 32'h0007);
    chk("legal_err", 32'(out_err), 32'd0);
    tick();
    chk("legal_drained", 32'(out_vld), 32'd0);

    // Complement n=14 on both instances.
    i_in_vld = 1'b1; i_in_n = 5'd14; i_in_inv = 1'b1;
    tick();
    i_in_vld = 1'b0; i_in_inv = 1'b0;
    chk("inv_en_x", 32'(out_x), 32'hC000);
    chk("inv_dis_x", 32'(nc_out_x), 32'h3FFF);
    tick();

    // Errored counts back-to-back.
    i_in_vld = 1'b1; i_in_inv = 1'b1; i_in_n = 5'd0;
    tick();
    chk("err0_x", 32'(out_x), 32'h0);
    chk("err0_err", 32'(out_err), 32'd1);
    chk("err0_cnt", 32'(err_cnt), 32'd1);
    i_in_n = 5'd16;
    tick();
    chk("err16_vld", 32'(out_vld), 32'd1);
    chk("err16_x", 32'(out_x), 32'h0);
    chk("err16_err", 32'(out_err), 32'd1);
    chk("err16_cnt", 32'(err_cnt), 32'd2);
    i_in_n = 5'd31;
    tick();
    chk("err31_x", 32'(out_x), 32'h0);
    chk("err31_err", 32'(out_err), 32'd1);
    chk("err31_cnt", 32'(err_cnt), 32'd3);
    i_in_vld = 1'b0; i_in_inv = 1'b0;
    tick();

    // Saturation: 300 more errored counts.
    i_in_vld = 1'b1; i_in_n = 5'd0;
    for (int i = 0; i < 300; i++) tick();
    i_in_vld = 1'b0;
    chk("err_sat", 32'(err_cnt), 32'd255);
    tick();

    // Backpressure into the skid register.
    i_out_rdy = 1'b0;
    i_in_vld = 1'b1; i_in_n = 5'd1;
    tick();
    chk("bp_rdy1", 32'(in_rdy), 32'd1);
    chk("bp_x1", 32'(out_x), 32'h0001);
    i_in_n = 5'd2;
    tick();
    chk("bp_full_rdy", 32'(in_rdy), 32'd0);
    i_in_n = 5'd3;
    tick();
    chk("bp_hold_rdy", 32'(in_rdy), 32'd0);
    chk("bp_hold_x", 32'(out_x), 32'h0001);
    i_out_rdy = 1'b1;
    tick();
    chk("bp_out2", 32'(out_x), 32'h0003);
    chk("bp_rdy_back", 32'(in_rdy), 32'd1);
    tick();
    i_in_vld = 1'b0;
    chk("bp_out3", 32'(out_x), 32'h0007);
    tick();
    chk("bp_empty", 32'(out_vld), 32'd0);

    // Reset while full.
    i_out_rdy = 1'b0;
    i_in_vld = 1'b1; i_in_n = 5'd5;
    tick();
    i_in_n = 5'd6;
    tick();
    i_in_vld = 1'b0;
    chk("mid_full", 32'(in_rdy), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_vld", 32'(out_vld), 32'd0);
    chk("mid_rdy", 32'(in_rdy), 32'd1);
    chk("mid_cnt", 32'(err_cnt), 32'd0);
    i_out_rdy = 1'b1;
    i_in_vld = 1'b1; i_in_n = 5'd2;
    tick();
    i_in_vld = 1'b0;
    chk("mid_first_x", 32'(out_x), 32'h0003);
    chk("mid_first_vld", 32'(out_vld), 32'd1);
    tick();

    // Random soak against an in-order scoreboard.
    for (int c = 0; c < 600; c++) begin
      i_in_vld  = 1'($urandom_range(0, 1));
      i_in_n    = 5'($urandom_range(0, 31));
      i_in_inv  = 1'($urandom_range(0, 1));
      i_out_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_vld && i_out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("soak_unexpected_out", 32'(out_vld), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("soak_x", 32'(out_x), 32'(e[W-1:0]));
          chk("soak_err", 32'(out_err), 32'(e[W]));
          if (!out_err) chk("soak_admit", 32'(admits(out_x, 1'b1)), 32'd1);
        end
      end
      if (i_in_vld && in_rdy) exp_q.push_back(model(int'(i_in_n), i_in_inv, 1'b1));
      tick();
    end
    i_in_vld  = 1'b0;
    i_out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          chk("soak_unexpected_out", 32'(out_vld), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("soak_drain_x", 32'(out_x), 32'(e[W-1:0]));
          chk("soak_drain_err", 32'(out_err), 32'(e[W]));
        end
      end
      tick();
    end
    chk("soak_leftover", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
